// File: rtl/uart_tx_engine.sv
// uart_tx_engine: pops bytes from the downstream FIFO and serialises each one
// as start / 8 data / optional parity / stop bit(s), every bit lasting
// bit_length_i clocks. Drives the TX busy status and started/done IRQ pulses.
module uart_tx_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int BITLEN_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [BITLEN_WIDTH-1:0] bit_length_i,
  input  logic [1:0]              stop_bit_mode_i,
  input  logic                    msb_first_i,
  input  logic                    hw_flow_ctrl_en_i,
  input  logic                    cts_n_i,
  input  logic                    dfifo_empty_i,
  input  logic [DATA_WIDTH-1:0]   dfifo_data_i,
  output logic                    dfifo_rd_o,
  output logic                    tx_o,
  output logic                    tx_busy_o,
  output logic                    irq_tx_started_o,
  output logic                    irq_tx_done_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BITLEN_WIDTH-1:0] LEN_ONE  = BITLEN_WIDTH'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [BITLEN_WIDTH-1:0] cnt_q;      // clocks left in the current bit, minus one
  logic [BITLEN_WIDTH-1:0] len_q;      // effective bit length latched at pop
  logic [IDX_W-1:0]        bit_idx_q;  // data bit currently on the line
  logic [DATA_WIDTH-1:0]   shift_q;    // remaining data bits, next one at [0]
  logic                    has_par_q;  // frame carries a parity bit
  logic                    par_q;      // parity bit value for this frame
  logic                    stop2_q;    // a second stop bit is still pending
  logic                    tx_q;
  logic                    started_q;

  logic [BITLEN_WIDTH-1:0] len_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    launch;

  // Launch decision and pop-cycle config: zero length becomes one, and the
  // byte is pre-ordered so the shifter always transmits bit [0] next.
  always_comb begin
    launch = !rst_i && (state_q == IDLE) && !dfifo_empty_i &&
             (!hw_flow_ctrl_en_i || !cts_n_i);
    len_d  = (bit_length_i == '0) ? LEN_ONE : bit_length_i;
    data_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data_d[i] = msb_first_i ? dfifo_data_i[DATA_WIDTH-1-i] : dfifo_data_i[i];
    end
  end

  // Frame sequencer: one bit-period down-counter, state advances when it hits zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      started_q <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      stop2_q   <= 1'b0;
    end else begin
      started_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (launch) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            started_q <= 1'b1;
            len_q     <= len_d;
            cnt_q     <= len_d - LEN_ONE;
            shift_q   <= data_d;
            bit_idx_q <= '0;
            has_par_q <= stop_bit_mode_i[1];
            par_q     <= (^dfifo_data_i) ^ stop_bit_mode_i[0];
            stop2_q   <= (stop_bit_mode_i == 2'b01);
          end
        end
        START: begin
          if (cnt_q == '0) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            cnt_q     <= len_q - LEN_ONE;
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= len_q - LEN_ONE;
            if (bit_idx_q == LAST_IDX) begin
              if (has_par_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        PARITY: begin
          if (cnt_q == '0) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            cnt_q   <= len_q - LEN_ONE;
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == '0) begin
            if (stop2_q) begin
              stop2_q <= 1'b0;
              cnt_q   <= len_q - LEN_ONE;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign dfifo_rd_o       = launch;
  assign tx_o             = tx_q;
  assign tx_busy_o        = (state_q != IDLE);
  assign irq_tx_started_o = started_q;
  // Last clock of the final stop bit, decoded purely from registered state.
  assign irq_tx_done_o    = (state_q == STOP) && (cnt_q == '0) && !stop2_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: drives uart_tx_engine from a byte queue standing in for
// the FIFO and compares every clock against a frame model built from
// run-length bit segments.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] bit_length_i;
  logic [1:0]  stop_bit_mode_i;
  logic        msb_first_i;
  logic        hw_flow_ctrl_en_i;
  logic        cts_n_i;
  logic        dfifo_empty_i;
  logic [7:0]  dfifo_data_i;
  logic        dfifo_rd_o;
  logic        tx_o;
  logic        tx_busy_o;
  logic        irq_tx_started_o;
  logic        irq_tx_done_o;

  uart_tx_engine #(.DATA_WIDTH(8), .BITLEN_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .bit_length_i     (bit_length_i),
    .stop_bit_mode_i  (stop_bit_mode_i),
    .msb_first_i      (msb_first_i),
    .hw_flow_ctrl_en_i(hw_flow_ctrl_en_i),
    .cts_n_i          (cts_n_i),
    .dfifo_empty_i    (dfifo_empty_i),
    .dfifo_data_i     (dfifo_data_i),
    .dfifo_rd_o       (dfifo_rd_o),
    .tx_o             (tx_o),
    .tx_busy_o        (tx_busy_o),
    .irq_tx_started_o (irq_tx_started_o),
    .irq_tx_done_o    (irq_tx_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              tx;
    longint unsigned len;
    bit              first;
    bit              last;
  } seg_t;

  seg_t            segq[$];
  longint unsigned pos = 0;
  logic [7:0]      fifo[$];
  longint          pop_cyc[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              push_cnt = 0;
  int              pop_cnt  = 0;
  int              st_cnt   = 0;
  int              dn_cnt   = 0;
  longint          cyc      = 0;
  bit              mon_en   = 1'b0;
  bit              pop_now  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected line activity for one frame, as (level, duration) runs.
  task automatic build_frame(input logic [7:0] d, input logic [31:0] bl,
                             input logic [1:0] mode, input bit msb);
    longint unsigned l;
    seg_t s;
    logic [7:0] dv;
    l  = (bl == 0) ? 1 : longint'(bl);
    dv = d;
    s.tx = 1'b0; s.len = l; s.first = 1'b1; s.last = 1'b0;
    segq.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.tx = msb ? dv[7-i] : dv[i]; s.len = l; s.first = 1'b0; s.last = 1'b0;
      segq.push_back(s);
    end
    if (mode[1]) begin
      s.tx = (^dv) ^ mode[0]; s.len = l; s.first = 1'b0; s.last = 1'b0;
      segq.push_back(s);
    end
    s.tx = 1'b1; s.len = (mode == 2'b01) ? 2 * l : l; s.first = 1'b0; s.last = 1'b1;
    segq.push_back(s);
  endtask

  // Per-clock comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit etx, ebusy, est, edn, erd;
    if (mon_en) begin
      if (segq.size() > 0) begin
        etx   = segq[0].tx;
        ebusy = 1'b1;
        est   = segq[0].first && (pos == 0);
        edn   = segq[0].last && (pos == segq[0].len - 1);
      end else begin
        etx = 1'b1; ebusy = 1'b0; est = 1'b0; edn = 1'b0;
      end
      erd = !rst_i && (segq.size() == 0) && !dfifo_empty_i &&
            (!hw_flow_ctrl_en_i || !cts_n_i);
      check_val("tx",      tx_o,             etx);
      check_val("busy",    tx_busy_o,        ebusy);
      check_val("started", irq_tx_started_o, est);
      check_val("done",    irq_tx_done_o,    edn);
      check_val("rd",      dfifo_rd_o,       erd);
      if (irq_tx_started_o) st_cnt++;
      if (irq_tx_done_o)    dn_cnt++;
      if (dfifo_rd_o) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        pop_now = 1'b1;
      end
      if (segq.size() > 0) begin
        pos++;
        if (pos == segq[0].len) begin
          void'(segq.pop_front());
          pos = 0;
        end
      end
      if (rst_i) begin
        segq.delete();
        pos = 0;
      end else if (erd) begin
        build_frame(dfifo_data_i, bit_length_i, stop_bit_mode_i, msb_first_i);
      end
    end
    cyc++;
  end

  task automatic upd_fifo();
    dfifo_empty_i = (fifo.size() == 0);
    dfifo_data_i  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    push_cnt++;
    upd_fifo();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_now) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pop_now = 1'b0;
    end
    upd_fifo();
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (fifo.size() == 0 && segq.size() == 0) begin
        done_ok = 1'b1;
        break;
      end
    end
    check_val(tag, done_ok, 1'b1);
  endtask

  task automatic cfg(input logic [31:0] bl, input logic [1:0] m, input bit msb);
    bit_length_i    = bl;
    stop_bit_mode_i = m;
    msb_first_i     = msb;
  endtask

  initial begin
    int p0, s0, d0;
    rst_i = 1'b1; hw_flow_ctrl_en_i = 1'b0; cts_n_i = 1'b1;
    cfg(32'd4, 2'b00, 1'b0);
    upd_fifo();
    @(posedge clk); #1;
    mon_en = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();

    // L=4, 8N1, 0x55
    s0 = st_cnt; d0 = dn_cnt;
    push(8'h55);
    wait_idle(200, "t1_drain");
    check_val("t1_started", st_cnt - s0, 1);
    check_val("t1_done",    dn_cnt - d0, 1);

    // Even then odd parity on 0xA3
    cfg(32'd2, 2'b10, 1'b0);
    push(8'hA3);
    wait_idle(200, "t2_even_drain");
    cfg(32'd2, 2'b11, 1'b0);
    push(8'hA3);
    wait_idle(200, "t2_odd_drain");

    // Two stop bits, MSB first
    cfg(32'd3, 2'b01, 1'b1);
    push(8'h01);
    wait_idle(200, "t3_drain");

    // Back-to-back at L=1
    cfg(32'd1, 2'b00, 1'b0);
    p0 = pop_cyc.size(); s0 = st_cnt; d0 = dn_cnt;
    push(8'h00);
    push(8'hFF);
    wait_idle(200, "t4_drain");
    check_val("t4_pops", pop_cyc.size() - p0, 2);
    if (pop_cyc.size() - p0 == 2)
      check_val("t4_pop_gap", pop_cyc[p0+1] - pop_cyc[p0], 11);
    check_val("t4_started", st_cnt - s0, 2);
    check_val("t4_done",    dn_cnt - d0, 2);

    // CTS hold-off, then CTS dropped mid-frame
    cfg(32'd2, 2'b00, 1'b0);
    hw_flow_ctrl_en_i = 1'b1; cts_n_i = 1'b1;
    p0 = pop_cnt;
    push(8'h3C);
    repeat (100) tick();
    check_val("t5_hold_pops", pop_cnt - p0, 0);
    cts_n_i = 1'b0;
    tick();
    check_val("t5_pop", pop_cnt - p0, 1);
    repeat (6) tick();
    cts_n_i = 1'b1;
    wait_idle(200, "t5_drain");
    hw_flow_ctrl_en_i = 1'b0;

    // Reset during data bit 3, then fresh frames including L=0
    cfg(32'd4, 2'b00, 1'b0);
    d0 = dn_cnt;
    push(8'h5A);
    tick();
    repeat (17) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("t6_no_done", dn_cnt - d0, 0);
    push(8'h96);
    wait_idle(200, "t6_fresh_drain");
    cfg(32'd0, 2'b10, 1'b0);
    push(8'hC3);
    wait_idle(100, "t6_len0_drain");

    // Maximum bit length: start bit must hold, then abort by reset
    cfg(32'hFFFF_FFFF, 2'b00, 1'b0);
    push(8'h11);
    repeat (40) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // Randomized traffic with config and CTS churn
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(8'($urandom));
      end
      cfg(32'($urandom_range(0, 4)), 2'($urandom), 1'($urandom));
      hw_flow_ctrl_en_i = 1'($urandom);
      cts_n_i           = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 25)) tick();
    end
    hw_flow_ctrl_en_i = 1'b0;
    cfg(32'd1, 2'b00, 1'b0);
    wait_idle(5000, "rand_drain");
    check_val("pops_eq_pushes", pop_cnt, push_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Transmit serializer between the downstream FIFO (DFIFO) and the UART TX pin. It pops one byte from DFIFO when idle and frames it as start, 8 data bits, optional parity and stop bits, with each bit lasting UART_BIT_LENGTH clocks. It drives the TX-side status bit and the tx_started/tx_done IRQ event pulses toward the register block.

Parameters:
DATA_WIDTH, 8, data bits per frame; matches DFIFO_WIDTH.
BITLEN_WIDTH, 32, width of the bit-length (clocks per bit) input.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
bit_length_i  input  BITLEN_WIDTH  clocks per UART bit (UART_BIT_LENGTH register)
stop_bit_mode_i  input  2  frame format (CTRL.stop_bit_mode)
msb_first_i  input  1  1 = transmit data MSB first (CTRL.msb_first)
hw_flow_ctrl_en_i  input  1  enable CTS gating (CTRL.hw_flow_ctrl_en)
cts_n_i  input  1  clear-to-send, active-low, already synchronized
dfifo_empty_i  input  1  DFIFO empty flag
dfifo_data_i  input  DATA_WIDTH  DFIFO head word (first-word-fall-through)
dfifo_rd_o  output  1  DFIFO pop strobe, one cycle
tx_o  output  1  serial line, idles high
tx_busy_o  output  1  STATS.tx_status; 1 = frame in progress
irq_tx_started_o  output  1  one-cycle pulse, IRQ_TX_STARTED event
irq_tx_done_o  output  1  one-cycle pulse, IRQ_TX_DONE event

Behaviour:
- Reset: state IDLE; tx_o=1; dfifo_rd_o=0; tx_busy_o=0; both IRQ outputs 0; all counters 0. Reset mid-frame aborts the frame, and tx_o returns to 1 on the next edge. No done pulse is produced for the aborted frame.
- stop_bit_mode encoding: 00 = no parity, 1 stop; 01 = no parity, 2 stop; 10 = even parity, 1 stop; 11 = odd parity, 1 stop.
- Parity bit: even = XOR of the 8 data bits; odd = inverted XOR.
- Effective bit length L = bit_length_i, except 0 is treated as 1.
- L, stop_bit_mode_i and msb_first_i are sampled on the pop cycle and held for the whole frame. Register changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the launch condition is dfifo_empty_i=0 AND (hw_flow_ctrl_en_i=0 OR cts_n_i=0).
  - IDLE on launch: assert dfifo_rd_o for exactly that cycle, latch dfifo_data_i and the config, then go to START.
  - START: tx_o=0 for L cycles. irq_tx_started_o pulses in the first START cycle.
  - DATA: 8 bits, L cycles each. Bit order is LSB first by default, or MSB first when msb_first_i=1.
  - PARITY: only in modes 10/11; L cycles.
  - STOP: tx_o=1 for L cycles (mode 01: 2L cycles). irq_tx_done_o pulses in the last STOP cycle, then the FSM returns to IDLE.
- Timing: tx_o and the state are registered. tx_o changes in the cycle after the pop (START).
- Frame length in clocks: (10 + P + S2)·L, where P = 1 for parity modes and S2 = 1 for mode 01.
- Inter-frame gap: exactly one IDLE cycle between the last STOP cycle and the next pop, so back-to-back frames are separated by 1 clock of tx_o=1.
- tx_busy_o = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- CTS is checked only in IDLE. Deasserting CTS mid-frame does not stop the frame; the next frame is held off until CTS asserts.
- Bit counter: 32-bit down-counter loaded with L-1, decremented each clock, with bit advance at 0. L = 0xFFFF_FFFF must work without overflow.
- DFIFO empty in IDLE: no pop, and tx_o stays 1 indefinitely.
- dfifo_rd_o is never asserted when dfifo_empty_i=1 or outside IDLE.

Test Plan:
1. L=4, mode 00, LSB first, push 0x55. Required: one pop cycle; next cycle tx_o=0 for 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then 1 for 4 clk. Total 40 clk. started pulse on the first START clk, done pulse at clk 40, tx_busy_o high for exactly 40 clk.
2. L=2, mode 10 (even) with 0xA3, then mode 11 (odd) with 0xA3. Required: parity bit 0 for even, 1 for odd, placed after bit 7; frame is 22 clk.
3. L=3, mode 01, msb_first=1, push 0x01. Required: data bits 0,0,0,0,0,0,0,1; stop high for 6 clk; frame is 33 clk.
4. Push 0x00 and 0xFF back-to-back with L=1, mode 00. Required: two pops 11 clk apart, exactly 1 idle clk between frames, and 2 started and 2 done pulses.
5. hw_flow_ctrl_en=1, cts_n_i=1, DFIFO non-empty. Required: no pop and tx_o=1 for 100 clk; pop occurs in the same cycle cts_n_i drops to 0. Raising cts_n_i mid-frame still completes the frame.
6. Assert rst_i in DATA bit 3 (L=4). Required: the next clk gives tx_o=1, tx_busy_o=0, no done pulse; after release, a fresh pop proceeds normally. Also bit_length_i=0 gives 1 clk per bit.
